// File: rtl/pim_bridge_pkg.sv
// Shared definitions for the PIM bus bridge.
//   state_t    : bridge FSM encoding
//   BUSY_BIT   : status word bit set while the PIM is working
//   VALID_BIT  : status word bit set once the PIM result is valid
//   DEAD_BEEF  : read data returned on an out-of-window access
package pim_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_POLL_ADDR,
    ST_POLL_DATA,
    ST_RESP
  } state_t;

  localparam int          BUSY_BIT  = 0;
  localparam int          VALID_BIT = 1;
  localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/pim_bus_bridge.sv
// CPU-to-PIM bus bridge. Converts single-outstanding req/ack transactions
// into the PIM address/data strobe interface. A write to SYNC_OFS blocks
// until the PIM status word reports valid && !busy, or POLL_TIMEOUT polls.
// Ports:
//   i_clk, i_rst           : clock, synchronous active-high reset
//   i_req/i_we/i_addr/i_wdata : CPU request (held until o_ack)
//   o_ack/o_rdata/o_err    : one-cycle completion, read data, error flag
//   o_pim_address/o_pim_data : strobes into the PIM (window offset, data)
//   i_pim_data             : PIM read data, valid one cycle after address
module pim_bus_bridge
  import pim_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0000,
  parameter int          SPAN_LOG2    = 16,
  parameter logic [15:0] STATUS_OFS   = 16'hFFFC,
  parameter logic [15:0] SYNC_OFS     = 16'hFFF8,
  parameter logic [31:0] IDLE_ADDR    = 32'h0,
  parameter int          POLL_TIMEOUT = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_ack,
  output logic [31:0] o_rdata,
  output logic        o_err,
  output logic [31:0] o_pim_address,
  output logic [31:0] o_pim_data,
  input  logic [31:0] i_pim_data
);

  // Unsigned subtract handles addresses below BASE_ADDR by wrapping high.
  function automatic logic in_window(input logic [31:0] a);
    logic [31:0] d;
    d = a - BASE_ADDR;
    return (d >> SPAN_LOG2) == 32'd0;
  endfunction

  state_t      state, nxt;
  logic [31:0] off_q, wdata_q, rdata_q;
  logic        err_q;
  logic [15:0] poll_cnt;
  logic [16:0] poll_inc;
  logic        poll_done, poll_tmo, is_sync, win;

  assign win       = in_window(i_addr);
  assign is_sync   = (off_q == {16'b0, SYNC_OFS});
  assign poll_inc  = {1'b0, poll_cnt} + 17'd1;
  assign poll_done = !i_pim_data[BUSY_BIT] && i_pim_data[VALID_BIT];
  assign poll_tmo  = ({15'b0, poll_inc} >= 32'(POLL_TIMEOUT));

  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= nxt;
  end

  // next state
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:      if (i_req) nxt = !win ? ST_RESP : (i_we ? ST_WR : ST_RD_ADDR);
      ST_WR:        nxt = is_sync ? ST_POLL_ADDR : ST_RESP;
      ST_RD_ADDR:   nxt = ST_RD_DATA;
      ST_RD_DATA:   nxt = ST_RESP;
      ST_POLL_ADDR: nxt = ST_POLL_DATA;
      ST_POLL_DATA: nxt = (poll_done || poll_tmo) ? ST_RESP : ST_POLL_ADDR;
      ST_RESP:      nxt = ST_IDLE;
      default:      nxt = ST_IDLE;
    endcase
  end

  // request latch and response datapath
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      off_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      poll_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: if (i_req) begin
          off_q   <= i_addr - BASE_ADDR;
          wdata_q <= i_wdata;
          err_q   <= !win;
          if (!win) rdata_q <= DEAD_BEEF;
          if (win && i_we) poll_cnt <= '0;
        end
        ST_RD_DATA: rdata_q <= i_pim_data;
        ST_POLL_DATA: begin
          poll_cnt <= poll_inc[15:0];
          if (poll_done) begin
            rdata_q <= i_pim_data;
          end else if (poll_tmo) begin
            rdata_q <= i_pim_data;
            err_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // outputs; reset masks the PIM strobes and any pending ack immediately
  always_comb begin
    o_ack         = 1'b0;
    o_pim_address = IDLE_ADDR;
    o_pim_data    = '0;
    if (!i_rst) begin
      case (state)
        ST_WR: begin
          o_pim_address = off_q;
          o_pim_data    = wdata_q;
        end
        ST_RD_ADDR:   o_pim_address = off_q;
        ST_POLL_ADDR: o_pim_address = {16'b0, STATUS_OFS};
        ST_RESP:      o_ack = 1'b1;
        default: ;
      endcase
    end
    o_err   = o_ack & err_q;
    o_rdata = rdata_q;
  end

endmodule

// File: tb/tb_pim_bus_bridge.sv
// Scoreboard bench for pim_bus_bridge with a simple PIM model.
module tb_pim_bus_bridge;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] STAT = 32'h0000_FFFC;
  localparam logic [31:0] SYNC = 32'h0000_FFF8;

  logic        clk = 1'b0;
  logic        rst, req, we;
  logic [31:0] addr, wdata;
  logic        ack, err;
  logic [31:0] rdata, pim_addr, pim_wdata, pim_rdata;

  always #5 clk = ~clk;

  pim_bus_bridge #(.POLL_TIMEOUT(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr),
    .i_wdata(wdata), .o_ack(ack), .o_rdata(rdata), .o_err(err),
    .o_pim_address(pim_addr), .o_pim_data(pim_wdata), .i_pim_data(pim_rdata)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // PIM model: status reads stay busy for busy_n polls after poll_base.
  int          poll_cnt_m = 0, poll_base = 0, busy_n = 0;
  logic [31:0] stat_final = 32'h2;
  always @(posedge clk) begin
    if (pim_addr == STAT) begin
      pim_rdata  <= ((poll_cnt_m - poll_base) < busy_n) ? 32'h1 : stat_final;
      poll_cnt_m <= poll_cnt_m + 1;
    end else if (pim_addr == 32'h20) begin
      pim_rdata <= 32'hA5A5_0001;
    end else begin
      pim_rdata <= pim_addr ^ 32'hC0DE_0000;
    end
  end

  // strobe monitor
  int nonidle = 0, wr_hits = 0;
  always @(negedge clk) begin
    if (pim_addr != 32'h0 || pim_wdata != 32'h0) nonidle <= nonidle + 1;
    if (pim_addr == 32'h10 && pim_wdata == 32'h1234_5678) wr_hits <= wr_hits + 1;
    if (err && !ack) chk("err_without_ack", {31'b0, err}, 32'h0);
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic        chk_rd;
  } exp_t;
  exp_t sb[$];

  function automatic exp_t mk(input logic [31:0] r, input logic e, input int l, input logic c);
    exp_t x;
    x.rdata = r; x.err = e; x.lat = l; x.chk_rd = c;
    return x;
  endfunction

  // Drive one request and compare the ack against the scoreboard head.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    bit   seen;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk);
    seen = 0;
    for (int lat = 1; lat <= 200 && !seen; lat++) begin
      @(negedge clk);
      if (lat == 1) begin
        addr  = $urandom;
        wdata = $urandom;
      end
      if (ack) begin
        seen = 1;
        if (sb.size() == 0) chk("sb_empty", 32'h1, 32'h0);
        else begin
          e = sb.pop_front();
          chk("latency", lat, e.lat);
          chk("err", {31'b0, err}, {31'b0, e.err});
          if (e.chk_rd) chk("rdata", rdata, e.rdata);
        end
      end
    end
    if (!seen) chk("ack_timeout", 32'h0, 32'h1);
    req = 1'b0; we = 1'b0;
  endtask

  int n0, w0, p0, acks;

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'b0, ack}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_pim_addr", pim_addr, 32'h0);
    chk("rst_pim_data", pim_wdata, 32'h0);
    rst = 1'b0;

    // normal write
    n0 = nonidle; w0 = wr_hits;
    sb.push_back(mk(32'h0, 1'b0, 2, 1'b0));
    txn(1'b1, BASE + 32'h10, 32'h1234_5678);
    chk("wr_strobe_cycles", wr_hits - w0, 1);
    chk("wr_nonidle_cycles", nonidle - n0, 1);

    // read
    n0 = nonidle;
    sb.push_back(mk(32'hA5A5_0001, 1'b0, 3, 1'b1));
    txn(1'b0, BASE + 32'h20, 32'h0);
    chk("rd_nonidle_cycles", nonidle - n0, 1);
    repeat (3) @(negedge clk);
    chk("rdata_hold", rdata, 32'hA5A5_0001);

    // sync write, 3 busy polls then done
    poll_base = poll_cnt_m; busy_n = 3; stat_final = 32'h2;
    n0 = nonidle;
    sb.push_back(mk(32'h2, 1'b0, 10, 1'b1));
    txn(1'b1, BASE + SYNC, 32'hCAFE_0001);
    chk("sync_polls", poll_cnt_m - poll_base, 4);
    chk("sync_nonidle_cycles", nonidle - n0, 5);

    // sync write, stuck busy -> timeout after 8 polls
    poll_base = poll_cnt_m; busy_n = 1000;
    sb.push_back(mk(32'h1, 1'b1, 18, 1'b1));
    txn(1'b1, BASE + SYNC, 32'hCAFE_0002);
    chk("tmo_polls", poll_cnt_m - poll_base, 8);

    // out-of-window accesses and window edges
    n0 = nonidle;
    sb.push_back(mk(32'hDEAD_BEEF, 1'b1, 1, 1'b1));
    txn(1'b0, 32'h0000_1000, 32'h0);
    chk("oow_nonidle_cycles", nonidle - n0, 0);
    sb.push_back(mk(32'hC0DE_FFFF, 1'b0, 3, 1'b1));
    txn(1'b0, BASE + 32'hFFFF, 32'h0);
    sb.push_back(mk(32'hDEAD_BEEF, 1'b1, 1, 1'b1));
    txn(1'b0, BASE + 32'h1_0000, 32'h0);
    n0 = nonidle;
    sb.push_back(mk(32'hDEAD_BEEF, 1'b1, 1, 1'b1));
    txn(1'b1, BASE - 32'h4, 32'h5555_AAAA);
    chk("oow_wr_nonidle_cycles", nonidle - n0, 0);

    // reset during POLL_DATA of a sync write
    poll_base = poll_cnt_m; busy_n = 1000;
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = BASE + SYNC; wdata = 32'h7;
    @(posedge clk);
    repeat (3) @(negedge clk);
    rst = 1'b1; req = 1'b0; we = 1'b0;
    @(negedge clk);
    chk("rst_mid_ack", {31'b0, ack}, 32'h0);
    chk("rst_mid_pim_addr", pim_addr, 32'h0);
    chk("rst_mid_polls", poll_cnt_m - poll_base, 1);
    rst = 1'b0;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack) acks++;
    end
    chk("rst_no_late_ack", acks, 0);

    sb.push_back(mk(32'hC0DE_0040, 1'b0, 3, 1'b1));
    txn(1'b0, BASE + 32'h40, 32'h0);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
